mem_port_arbiter: RTL

Sequential arbiter that shares the single unified memory port between the instruction-fetch stage (IF) and the data-memory stage (DM) of the pipelined RISC-V core. It owns the `Selector` input of the 2:1 multiplexers that steer address and write data onto the memory port. It runs a variable-latency request/ready handshake with the memory and stalls whichever requester is waiting. It grants round-robin on contention, bounds every transaction with a timeout counter, and flags a sticky bus error.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch (IF) and
// data memory (DM). Round-robin on contention, variable-latency request/ready
// handshake, per-transaction timeout, and a sticky bus error flag.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   if_req, dm_req      requests, held high until the matching done pulse
//   dm_we               DM access is a store (valid while dm_req)
//   mem_ready           memory completes the current access this cycle
//   mux_sel             address/wdata mux select: 0 = IF, 1 = DM
//   mem_req, mem_we     memory port request / write enable
//   if_done, dm_done    one-cycle completion pulses
//   if_stall, dm_stall  combinational hold signals for the pipeline
//   busy                a grant is in progress
//   bus_error           sticky: some access timed out
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_we,
  input  logic mem_ready,
  output logic mux_sel,
  output logic mem_req,
  output logic mem_we,
  output logic if_done,
  output logic dm_done,
  output logic if_stall,
  output logic dm_stall,
  output logic busy,
  output logic bus_error
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 mux_sel_q, mux_sel_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic                 if_done_q, if_done_d;
  logic                 dm_done_q, dm_done_d;
  logic                 bus_error_q, bus_error_d;
  logic                 last_dm_q, last_dm_d;   // last_served: 0 = IF, 1 = DM
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic if_elig, dm_elig;

  // A requester is not eligible in its own done cycle: its req is still the
  // old, already-served request.
  assign if_elig = if_req & ~if_done_q;
  assign dm_elig = dm_req & ~dm_done_q;

  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    bus_error_d = bus_error_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        // IF wins when it is alone or when DM was served last.
        if (if_elig && (!dm_elig || last_dm_q)) begin
          state_d   = GNT_IF;
          mux_sel_d = 1'b0;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          last_dm_d = 1'b0;
        end else if (dm_elig) begin
          state_d   = GNT_DM;
          mux_sel_d = 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = dm_we;
          cnt_d     = '0;
          last_dm_d = 1'b1;
        end
      end
      GNT_IF, GNT_DM: begin
        if (mem_ready || cnt_q == CNT_LAST) begin
          // Completion and timeout share the same exit; timeout also
          // raises the sticky error.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == GNT_IF) if_done_d = 1'b1;
          else                   dm_done_d = 1'b1;
          if (!mem_ready) bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_sel_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_error_q <= 1'b0;
      last_dm_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      bus_error_q <= bus_error_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign bus_error = bus_error_q;
  assign busy      = (state_q != IDLE);
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule
